// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light FSM and its request conditioner:
// state encodings, the lights output codes and the default grant codes.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5,
      S6 = 3'd6,
      S7 = 3'd7
   } tl_state_e;

   localparam logic [11:0] LIGHTS_S0 = 12'h849;
   localparam logic [11:0] LIGHTS_S1 = 12'h449;
   localparam logic [11:0] LIGHTS_S2 = 12'h309;
   localparam logic [11:0] LIGHTS_S3 = 12'h289;
   localparam logic [11:0] LIGHTS_S4 = 12'h261;
   localparam logic [11:0] LIGHTS_S5 = 12'h251;
   localparam logic [11:0] LIGHTS_S6 = 12'h24C;
   localparam logic [11:0] LIGHTS_S7 = 12'h24A;

   // Entry into these codes means the FSM has started serving that request.
   localparam logic [11:0] LIGHTS_V_GRANT_DEF = LIGHTS_S4;
   localparam logic [11:0] LIGHTS_Z_GRANT_DEF = LIGHTS_S6;

   // Lights code driven by the FSM in a given state.
   function automatic logic [11:0] lights_of(input tl_state_e s);
      logic [11:0] code;
      code = LIGHTS_S0;
      case (s)
         S0: code = LIGHTS_S0;
         S1: code = LIGHTS_S1;
         S2: code = LIGHTS_S2;
         S3: code = LIGHTS_S3;
         S4: code = LIGHTS_S4;
         S5: code = LIGHTS_S5;
         S6: code = LIGHTS_S6;
         S7: code = LIGHTS_S7;
         default: code = LIGHTS_S0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, stability counter and a
// single-cycle pulse on each debounced rising edge.
module sensor_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic rise_o
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES);

   logic       sync1_q, sync2_q;
   logic       deb_q, deb_d;
   logic       deb_dly_q;
   logic [7:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the debounced level;
   // flip the level on the sample that completes the run.
   always_comb begin
      cnt_d = 8'd0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
         if (cnt_q + 8'd1 == CNT_LAST) begin
            deb_d = ~deb_q;
            cnt_d = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Synchronizer, debounce state and the delayed level for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         sync1_q   <= raw_i;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         cnt_q     <= cnt_d;
      end
   end

   // Falling edges are deliberately dropped: a held sensor is one request.
   assign rise_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Turns raw vehicle/pedestrian sensors into latched V/Z requests for the
// traffic light FSM, clearing them on grant and keeping V from starving Z.
module traffic_request_conditioner
   import traffic_light_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MAX_V_SKIP      = 2,
   parameter logic [11:0] LIGHTS_V_GRANT  = LIGHTS_V_GRANT_DEF,
   parameter logic [11:0] LIGHTS_Z_GRANT  = LIGHTS_Z_GRANT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        raw_v,
   input  logic        raw_z,
   input  logic [11:0] lights,
   output logic        V,
   output logic        Z,
   output logic        v_masked
);

   localparam logic [3:0] SKIP_MAX = 4'(MAX_V_SKIP);

   logic        rise_v, rise_z;
   logic        grant_v, grant_z;
   logic [11:0] lights_q;
   logic        req_v_q, req_v_d;
   logic        req_z_q, req_z_d;
   logic [3:0]  skip_q, skip_d;
   logic        mask_q, mask_d;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_v (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw_v),
      .rise_o (rise_v)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_z (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw_z),
      .rise_o (rise_z)
   );

   // A grant is the first cycle the lights show the service code, so a
   // code held for many cycles counts once.
   always_comb begin
      grant_v = (lights == LIGHTS_V_GRANT) && (lights_q != LIGHTS_V_GRANT);
      grant_z = (lights == LIGHTS_Z_GRANT) && (lights_q != LIGHTS_Z_GRANT);
   end

   // Request latches (a new rise beats a same-cycle grant) and the skip
   // counter that masks V after too many V services while Z waits.
   always_comb begin
      req_v_d = rise_v | (req_v_q & ~grant_v);
      req_z_d = rise_z | (req_z_q & ~grant_z);
      skip_d  = skip_q;
      if (grant_z || !req_z_q) begin
         skip_d = 4'd0;
      end else if (grant_v && (skip_q < SKIP_MAX)) begin
         skip_d = skip_q + 4'd1;
      end
      mask_d = (skip_d == SKIP_MAX);
   end

   // Request, fairness and lights history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         lights_q <= 12'h000;
         req_v_q  <= 1'b0;
         req_z_q  <= 1'b0;
         skip_q   <= 4'd0;
         mask_q   <= 1'b0;
      end else begin
         lights_q <= lights;
         req_v_q  <= req_v_d;
         req_z_q  <= req_z_d;
         skip_q   <= skip_d;
         mask_q   <= mask_d;
      end
   end

   // A masked V request stays latched and shows again once the mask drops.
   assign V        = req_v_q & ~mask_q;
   assign Z        = req_z_q;
   assign v_masked = mask_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Bench for traffic_request_conditioner: directed scenarios against fixed
// expectations, then random sensor/lights traffic against a window model.
module tb_traffic_request_conditioner;

   localparam int DEB  = 4;
   localparam int MAXS = 2;
   localparam logic [11:0] VG = 12'h261;
   localparam logic [11:0] ZG = 12'h24C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rv  = 1'b0;
   logic        rz  = 1'b0;
   logic [11:0] lt  = 12'h000;
   logic        V, Z, v_masked;

   int total = 0;
   int bad   = 0;

   traffic_request_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .MAX_V_SKIP     (MAXS),
      .LIGHTS_V_GRANT (VG),
      .LIGHTS_Z_GRANT (ZG)
   ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .raw_v    (rv),
      .raw_z    (rz),
      .lights   (lt),
      .V        (V),
      .Z        (Z),
      .v_masked (v_masked)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Channel 0 = vehicle, 1 = pedestrian. The debounced level flips once the
   // last DEB synchronized samples seen since the previous flip all disagree.
   logic m_rq[2][$];
   logic m_hist[2][$];
   logic m_deb[2];
   logic m_debp[2];
   logic m_req_v = 1'b0, m_req_z = 1'b0, m_mask = 1'b0;
   int   m_skip = 0;
   logic [11:0] m_lprev = 12'h000;

   task automatic model_step();
      logic rise[2];
      logic gv, gz, s2, rawc, all_diff;
      int nskip;
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            m_rq[c].delete();
            m_rq[c].push_back(1'b0);
            m_rq[c].push_back(1'b0);
            m_hist[c].delete();
            m_deb[c]  = 1'b0;
            m_debp[c] = 1'b0;
         end
         m_req_v = 1'b0; m_req_z = 1'b0; m_skip = 0; m_mask = 1'b0;
         m_lprev = 12'h000;
      end else begin
         for (int c = 0; c < 2; c++) rise[c] = m_deb[c] & ~m_debp[c];
         gv = (lt == VG) && (m_lprev != VG);
         gz = (lt == ZG) && (m_lprev != ZG);
         if (gz || !m_req_z) nskip = 0;
         else if (gv && m_skip < MAXS) nskip = m_skip + 1;
         else nskip = m_skip;
         m_req_v = rise[0] | (m_req_v & ~gv);
         m_req_z = rise[1] | (m_req_z & ~gz);
         m_skip  = nskip;
         m_mask  = (nskip == MAXS);
         m_lprev = lt;
         for (int c = 0; c < 2; c++) begin
            rawc = (c == 0) ? rv : rz;
            s2 = m_rq[c].pop_front();
            m_rq[c].push_back(rawc);
            m_debp[c] = m_deb[c];
            m_hist[c].push_back(s2);
            if (m_hist[c].size() > DEB) void'(m_hist[c].pop_front());
            if (m_hist[c].size() == DEB) begin
               all_diff = 1'b1;
               for (int k = 0; k < DEB; k++)
                  if (m_hist[c][k] == m_deb[c]) all_diff = 1'b0;
               if (all_diff) begin
                  m_deb[c] = ~m_deb[c];
                  m_hist[c].delete();
               end
            end
         end
      end
   endtask

   // One clock edge; the model sees the same inputs as the DUT at that edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rv = 1'b0; rz = 1'b0; lt = 12'h000;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Drop then raise a sensor long enough to produce one clean request.
   task automatic press(input int c);
      if (c == 0) rv = 1'b0; else rz = 1'b0;
      repeat (8) tick();
      if (c == 0) rv = 1'b1; else rz = 1'b1;
      repeat (8) tick();
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; rv = 1'b1; rz = 1'b1; lt = VG;
      repeat (3) tick();
      total++;
      if ({V, Z, v_masked} !== 3'b000) begin
         bad++;
         $display("FAIL reset_outputs: got %b expected 000", {V, Z, v_masked});
      end
      rst = 1'b0; rv = 1'b0; rz = 1'b0; lt = 12'h000;
   endtask

   task automatic test_latency();
      do_reset();
      rv = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         total++;
         if (V !== (e == 7)) begin
            bad++;
            $display("FAIL latency_v_edge%0d: got %b expected %b", e, V, (e == 7));
         end
         total++;
         if ({Z, v_masked} !== 2'b00) begin
            bad++;
            $display("FAIL latency_z_mask_edge%0d: got %b expected 00", e, {Z, v_masked});
         end
      end
   endtask

   task automatic test_short_pulse();
      logic seen;
      do_reset();
      rz = 1'b1;
      repeat (3) tick();
      rz = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (Z !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL short_pulse_z: got Z asserted expected never");
      end
      total++;
      if (u_dut.u_deb_z.cnt_q !== 8'd0) begin
         bad++;
         $display("FAIL short_pulse_cnt: got %0d expected 0", u_dut.u_deb_z.cnt_q);
      end
   endtask

   task automatic test_grant_once();
      do_reset();
      rv = 1'b1;
      repeat (8) tick();
      lt = 12'h289; tick();
      total++;
      if (V !== 1'b1) begin
         bad++; $display("FAIL grant_pre_v: got %b expected 1", V);
      end
      lt = VG; tick();
      total++;
      if (V !== 1'b0) begin
         bad++; $display("FAIL grant_clears_v: got %b expected 0", V);
      end
      press(0);
      total++;
      if (V !== 1'b1) begin
         bad++; $display("FAIL grant_held_rerequest: got %b expected 1", V);
      end
      repeat (5) tick();
      total++;
      if (V !== 1'b1) begin
         bad++; $display("FAIL grant_held_once: got %b expected 1", V);
      end
      lt = 12'h251; tick();
      total++;
      if (V !== 1'b1) begin
         bad++; $display("FAIL grant_leave_code: got %b expected 1", V);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      lt = 12'h289;
      rz = 1'b1;
      repeat (8) tick();
      for (int g = 1; g <= 2; g++) begin
         press(0);
         total++;
         if (V !== 1'b1) begin
            bad++; $display("FAIL fair_v_req%0d: got %b expected 1", g, V);
         end
         lt = VG; tick();
         lt = 12'h289; tick();
         total++;
         if (v_masked !== (g == 2)) begin
            bad++; $display("FAIL fair_mask_after%0d: got %b expected %b", g, v_masked, (g == 2));
         end
      end
      press(0);
      total++;
      if ({V, Z, v_masked} !== 3'b011) begin
         bad++; $display("FAIL fair_masked_pending: got %b expected 011", {V, Z, v_masked});
      end
      lt = ZG; tick();
      total++;
      if ({V, Z, v_masked} !== 3'b100) begin
         bad++; $display("FAIL fair_z_grant: got %b expected 100", {V, Z, v_masked});
      end
   endtask

   task automatic test_set_wins();
      do_reset();
      rv = 1'b1;
      repeat (8) tick();
      rv = 1'b0;
      repeat (8) tick();
      lt = 12'h289;
      rv = 1'b1;
      repeat (6) tick();
      lt = VG;
      tick();
      total++;
      if (V !== 1'b1) begin
         bad++; $display("FAIL set_wins_edge: got %b expected 1", V);
      end
      tick();
      total++;
      if (V !== 1'b1) begin
         bad++; $display("FAIL set_wins_after: got %b expected 1", V);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      rv = 1'b1; rz = 1'b1;
      repeat (8) tick();
      lt = 12'h289; tick();
      lt = VG; tick();
      press(0);
      total++;
      if ({V, Z, v_masked} !== 3'b110) begin
         bad++; $display("FAIL midrst_pre: got %b expected 110", {V, Z, v_masked});
      end
      total++;
      if (u_dut.skip_q !== 4'd1) begin
         bad++; $display("FAIL midrst_skip: got %0d expected 1", u_dut.skip_q);
      end
      rst = 1'b1; tick();
      rst = 1'b0; lt = 12'h289;
      total++;
      if ({V, Z, v_masked} !== 3'b000) begin
         bad++; $display("FAIL midrst_clear: got %b expected 000", {V, Z, v_masked});
      end
      for (int e = 1; e <= 7; e++) begin
         tick();
         total++;
         if (V !== (e == 7)) begin
            bad++; $display("FAIL midrst_relatch_edge%0d: got %b expected %b", e, V, (e == 7));
         end
      end
   endtask

   // ---------------- randomized traffic vs model ----------------
   task automatic test_random();
      logic [11:0] codes[8];
      int hv, hz, hl, shown;
      logic ev, ez, em;
      codes = '{12'h849, 12'h449, 12'h309, 12'h289, 12'h261, 12'h251, 12'h24C, 12'h24A};
      do_reset();
      hv = 0; hz = 0; hl = 0; shown = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hv == 0) begin rv = 1'($urandom_range(0, 1)); hv = $urandom_range(1, 9); end
         if (hz == 0) begin rz = 1'($urandom_range(0, 1)); hz = $urandom_range(1, 12); end
         if (hl == 0) begin
            if ($urandom_range(0, 9) == 0) lt = 12'($urandom);
            else lt = codes[$urandom_range(0, 7)];
            hl = $urandom_range(1, 6);
         end
         rst = ($urandom_range(0, 399) == 0);
         hv--; hz--; hl--;
         tick();
         ev = m_req_v & ~m_mask;
         ez = m_req_z;
         em = m_mask;
         total++;
         if ({V, Z, v_masked} !== {ev, ez, em}) begin
            bad++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random_cyc%0d: got VZM=%b expected %b", cyc, {V, Z, v_masked}, {ev, ez, em});
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_latency();
      test_short_pulse();
      test_grant_once();
      test_fairness();
      test_set_wins();
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
